// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU datapath and its UART-facing interface:
//   sequencer state encoding, default widths and ALU opcode constants.
//   Imported by alu_interface, byte_timeout, the ALU and testbenches.
package alu_pkg;

  localparam int NB_DATA_DEFAULT   = 8;
  localparam int NB_OPCODE_DEFAULT = 6;

  // Sequencer states; the 3-bit encoding leaves three unused codes, which
  // the FSM folds back to ST_WAIT_A.
  typedef enum logic [2:0] {
    ST_WAIT_A   = 3'd0,
    ST_WAIT_B   = 3'd1,
    ST_WAIT_OP  = 3'd2,
    ST_COMPUTE  = 3'd3,
    ST_WAIT_TX  = 3'd4
  } state_t;

  // ALU opcodes (MIPS funct-style encoding)
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/byte_timeout.sv
// byte_timeout
//   Inter-byte watchdog. Counts enabled cycles and raises `expired` (one
//   cycle, combinational from the count) when LIMIT cycles have passed
//   without a clear. The count restarts whenever `clear` is high or the
//   counter is disabled, so it always measures time since the last event.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   clear   in  restart the count (byte accepted)
//   enable  in  count this cycle
//   expired out high on the cycle the count reaches LIMIT-1 while enabled
module byte_timeout
  import alu_pkg::*;
#(
  parameter int LIMIT = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  assign expired = enable && (count_reg == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || !enable || expired) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/alu_interface.sv
// alu_interface
//   Sequences three UART bytes (operand A, operand B, opcode) into registered
//   ALU inputs, waits one cycle for the combinational ALU, then hands the
//   result to the UART transmitter and waits for it to finish.
//   Optional macro ALU_IF_TIMEOUT_EN: abort a partial sequence back to
//   WAIT_A when TIMEOUT_CYCLES pass between bytes (timeout pulses once).
//   Without it the FSM waits indefinitely and timeout stays 0.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_data, rx_done    byte from UART receiver, one-cycle valid pulse
//   alu_result          combinational ALU output
//   tx_done             transmitter finished pulse
//   dato_a, dato_b      registered operands to ALU
//   opcode              registered opcode to ALU
//   tx_data, tx_start   result byte and start pulse to transmitter
//   busy                high in COMPUTE and WAIT_TX
//   overrun             sticky: byte dropped while busy
//   timeout             one-cycle pulse: sequence aborted
module alu_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NB_DATA-1:0]   rx_data,
  input  logic                 rx_done,
  input  logic [NB_DATA-1:0]   alu_result,
  input  logic                 tx_done,
  output logic [NB_DATA-1:0]   dato_a,
  output logic [NB_DATA-1:0]   dato_b,
  output logic [NB_OPCODE-1:0] opcode,
  output logic [NB_DATA-1:0]   tx_data,
  output logic                 tx_start,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout
);

  state_t               state_reg;
  logic [NB_DATA-1:0]   dato_a_reg;
  logic [NB_DATA-1:0]   dato_b_reg;
  logic [NB_OPCODE-1:0] opcode_reg;
  logic [NB_DATA-1:0]   tx_data_reg;
  logic                 tx_start_reg;
  logic                 busy_reg;
  logic                 overrun_reg;
  logic                 timeout_reg;
  logic                 expired;

`ifdef ALU_IF_TIMEOUT_EN
  // Counting only in WAIT_B/WAIT_OP; being disabled in any other state
  // also restarts the count, which covers re-entry to WAIT_A.
  byte_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_done),
    .enable  ((state_reg == ST_WAIT_B) || (state_reg == ST_WAIT_OP)),
    .expired (expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_WAIT_A;
      dato_a_reg   <= '0;
      dato_b_reg   <= '0;
      opcode_reg   <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      timeout_reg  <= 1'b0;
      case (state_reg)
        ST_WAIT_A: begin
          if (rx_done) begin
            dato_a_reg <= rx_data;
            state_reg  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          // An incoming byte beats a simultaneous expiry.
          if (rx_done) begin
            dato_b_reg <= rx_data;
            state_reg  <= ST_WAIT_OP;
          end else if (expired) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          if (rx_done) begin
            opcode_reg <= rx_data[NB_OPCODE-1:0];
            busy_reg   <= 1'b1;
            state_reg  <= ST_COMPUTE;
          end else if (expired) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_WAIT_A;
          end
        end
        ST_COMPUTE: begin
          // Operands settled at the previous edge, so alu_result is valid.
          tx_data_reg  <= alu_result;
          tx_start_reg <= 1'b1;
          state_reg    <= ST_WAIT_TX;
          if (rx_done) overrun_reg <= 1'b1;
        end
        ST_WAIT_TX: begin
          if (rx_done) overrun_reg <= 1'b1;
          if (tx_done) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_WAIT_A;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign dato_a   = dato_a_reg;
  assign dato_b   = dato_b_reg;
  assign opcode   = opcode_reg;
  assign tx_data  = tx_data_reg;
  assign tx_start = tx_start_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_alu_interface.sv
// tb_alu_interface
//   Directed-vector bench for alu_interface with a behavioural ALU model
//   closing the loop from dato_a/dato_b/opcode back to alu_result.
//   Built with or without ALU_IF_TIMEOUT_EN; the timeout scenario adapts.
module tb_alu_interface;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] alu_result;
  logic       tx_done = 1'b0;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [5:0] opcode;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  alu_interface #(
    .NB_DATA        (8),
    .NB_OPCODE      (6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .alu_result (alu_result),
    .tx_done    (tx_done),
    .dato_a     (dato_a),
    .dato_b     (dato_b),
    .opcode     (opcode),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  // Behavioural ALU
  always_comb begin
    alu_result = 8'h00;
    case (opcode)
      OP_ADD: alu_result = dato_a + dato_b;
      OP_SUB: alu_result = dato_a - dato_b;
      OP_AND: alu_result = dato_a & dato_b;
      OP_OR:  alu_result = dato_a | dato_b;
      OP_XOR: alu_result = dato_a ^ dato_b;
      OP_SRA: alu_result = $signed(dato_a) >>> dato_b;
      OP_SRL: alu_result = dato_a >> dato_b;
      OP_NOR: alu_result = ~(dato_a | dato_b);
      default: alu_result = 8'h00;
    endcase
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    $display("rx byte %02h -> a=%02h b=%02h op=%02h busy=%0b", b, dato_a, dato_b, opcode, busy);
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    $display("tx_done pulse -> busy=%0b", busy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks_total++;
    if ({dato_a, dato_b, opcode, tx_data, tx_start, busy, overrun, timeout} !== 34'd0)
      $display("FAIL reset_outputs: got a=%02h b=%02h op=%02h tx=%02h st=%0b bz=%0b ov=%0b to=%0b expected all 0",
               dato_a, dato_b, opcode, tx_data, tx_start, busy, overrun, timeout);
    else checks_passed++;
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_add();
    send_byte(8'h05);
    checks_total++;
    if (dato_a !== 8'h05) $display("FAIL add_dato_a: got %02h expected 05", dato_a);
    else checks_passed++;
    send_byte(8'h03);
    checks_total++;
    if (dato_b !== 8'h03) $display("FAIL add_dato_b: got %02h expected 03", dato_b);
    else checks_passed++;
    send_byte(8'h20);
    // After edge K: opcode captured, busy high, tx_start not yet
    checks_total++;
    if ({opcode, busy, tx_start} !== {6'h20, 1'b1, 1'b0})
      $display("FAIL add_edge_k: got op=%02h busy=%0b st=%0b expected 20/1/0", opcode, busy, tx_start);
    else checks_passed++;
    @(negedge clk); // after K+1
    checks_total++;
    if ({tx_data, tx_start} !== {8'h08, 1'b1})
      $display("FAIL add_edge_k1: got tx=%02h st=%0b expected 08/1", tx_data, tx_start);
    else checks_passed++;
    @(negedge clk); // after K+2
    checks_total++;
    if ({tx_start, busy} !== 2'b01)
      $display("FAIL add_edge_k2: got st=%0b busy=%0b expected 0/1", tx_start, busy);
    else checks_passed++;
    pulse_tx_done();
    checks_total++;
    if (busy !== 1'b0) $display("FAIL add_busy_clear: got %0b expected 0", busy);
    else checks_passed++;
  endtask

  task automatic test_sub_wrap();
    send_byte(8'h03);
    send_byte(8'h05);
    send_byte(8'hE2);
    checks_total++;
    if (opcode !== 6'h22) $display("FAIL sub_opcode_trunc: got %02h expected 22", opcode);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if ({tx_data, tx_start} !== {8'hFE, 1'b1})
      $display("FAIL sub_tx_data: got tx=%02h st=%0b expected FE/1", tx_data, tx_start);
    else checks_passed++;
  endtask

  // Entered while in WAIT_TX from test_sub_wrap
  task automatic test_overrun();
    checks_total++;
    if (overrun !== 1'b0) $display("FAIL overrun_initial: got %0b expected 0", overrun);
    else checks_passed++;
    send_byte(8'h11);
    checks_total++;
    if ({overrun, busy, dato_a, tx_data} !== {1'b1, 1'b1, 8'h03, 8'hFE})
      $display("FAIL overrun_drop: got ov=%0b busy=%0b a=%02h tx=%02h expected 1/1/03/FE",
               overrun, busy, dato_a, tx_data);
    else checks_passed++;
    pulse_tx_done();
    send_byte(8'h44);
    checks_total++;
    if ({dato_a, dato_b, overrun} !== {8'h44, 8'h05, 1'b1})
      $display("FAIL overrun_after_tx: got a=%02h b=%02h ov=%0b expected 44/05/1", dato_a, dato_b, overrun);
    else checks_passed++;
  endtask

  // Entered in WAIT_B with dato_a=0x44: B and opcode on consecutive cycles
  task automatic test_back_to_back();
    @(negedge clk);
    rx_data = 8'h10;
    rx_done = 1'b1;
    @(negedge clk);
    rx_data = 8'h25; // OR
    @(negedge clk);
    rx_done = 1'b0;
    $display("back-to-back bytes 10,25 -> b=%02h op=%02h busy=%0b", dato_b, opcode, busy);
    checks_total++;
    if ({dato_b, opcode, busy} !== {8'h10, 6'h25, 1'b1})
      $display("FAIL b2b_capture: got b=%02h op=%02h busy=%0b expected 10/25/1", dato_b, opcode, busy);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if ({tx_data, tx_start} !== {8'h54, 1'b1})
      $display("FAIL b2b_result: got tx=%02h st=%0b expected 54/1", tx_data, tx_start);
    else checks_passed++;
    pulse_tx_done();
  endtask

  task automatic test_midseq_reset();
    pulse_tx_done(); // ignored in WAIT_A
    send_byte(8'hAA);
    checks_total++;
    if ({dato_a, busy} !== {8'hAA, 1'b0})
      $display("FAIL rst_pre_a: got a=%02h busy=%0b expected AA/0", dato_a, busy);
    else checks_passed++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    // Asynchronous: outputs clear before any clock edge
    checks_total++;
    if ({dato_a, dato_b, opcode, tx_data, tx_start, busy, overrun, timeout} !== 34'd0)
      $display("FAIL rst_async_clear: got a=%02h b=%02h op=%02h tx=%02h ov=%0b expected all 0",
               dato_a, dato_b, opcode, tx_data, overrun);
    else checks_passed++;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h5A);
    send_byte(8'h5B);
    checks_total++;
    if ({dato_a, dato_b} !== {8'h5A, 8'h5B})
      $display("FAIL rst_reload: got a=%02h b=%02h expected 5A/5B", dato_a, dato_b);
    else checks_passed++;
  endtask

  task automatic test_timeout();
    int pulses;
    int idle;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h09);
    pulses = 0;
`ifdef ALU_IF_TIMEOUT_EN
    idle = 20;
`else
    idle = 1000;
`endif
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    $display("idle %0d cycles in WAIT_B -> timeout high cycles=%0d", idle, pulses);
`ifdef ALU_IF_TIMEOUT_EN
    checks_total++;
    if (pulses !== 1) $display("FAIL timeout_pulse: got %0d cycles expected 1", pulses);
    else checks_passed++;
    send_byte(8'h07);
    checks_total++;
    if ({dato_a, dato_b} !== {8'h07, 8'h00})
      $display("FAIL timeout_reload: got a=%02h b=%02h expected 07/00", dato_a, dato_b);
    else checks_passed++;
`else
    checks_total++;
    if (pulses !== 0) $display("FAIL no_timeout: got %0d cycles expected 0", pulses);
    else checks_passed++;
    send_byte(8'h07);
    checks_total++;
    if ({dato_a, dato_b} !== {8'h09, 8'h07})
      $display("FAIL no_timeout_b: got a=%02h b=%02h expected 09/07", dato_a, dato_b);
    else checks_passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_overrun();
    test_back_to_back();
    test_midseq_reset();
    test_timeout();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/alu_interface.md
# alu_interface

Upstream sequencing stage for the ALU: collects three bytes from the UART receiver (operand A, operand B, opcode), presents them as registered `dato_a`, `dato_b` and `opcode` to the combinational ALU, captures the ALU result, and hands it to the UART transmitter. It sits between `uart_rx`/`uart_tx` and `ALU` in the board top level, replacing switch/button operand loading.

## Interface
- `NB_DATA`, 8, width of UART bytes, ALU operands and result
- `NB_OPCODE`, 6, ALU opcode width; taken from `rx_data[NB_OPCODE-1:0]`
- `TIMEOUT_CYCLES`, 50_000_000, inter-byte timeout in clock cycles; used only with `ALU_IF_TIMEOUT_EN`
- `clk` input 1 system clock, all logic on rising edge
- `reset` input 1 asynchronous, active-high; one clock domain only
- `rx_data` input NB_DATA byte from UART receiver, valid while `rx_done`=1
- `rx_done` input 1 one-cycle pulse, byte available
- `alu_result` input NB_DATA combinational ALU output
- `tx_done` input 1 one-cycle pulse, transmitter finished
- `dato_a` output NB_DATA registered operand A to ALU
- `dato_b` output NB_DATA registered operand B to ALU
- `opcode` output NB_OPCODE registered opcode to ALU
- `tx_data` output NB_DATA registered result byte to transmitter
- `tx_start` output 1 one-cycle pulse, start transmission
- `busy` output 1 high in COMPUTE and WAIT_TX
- `overrun` output 1 sticky: byte arrived while busy and was dropped
- `timeout` output 1 one-cycle pulse, sequence aborted by timeout

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, WAIT_TX. Reset state WAIT_A.
- WAIT_A + `rx_done`: `dato_a`<=`rx_data`, ->WAIT_B. WAIT_B + `rx_done`: `dato_b`<=`rx_data`, ->WAIT_OP.
- WAIT_OP + `rx_done`: `opcode`<=`rx_data[NB_OPCODE-1:0]` (upper bits discarded), ->COMPUTE.
- COMPUTE (exactly one cycle): `tx_data`<=`alu_result`, `tx_start`<=1, ->WAIT_TX.
- WAIT_TX: `tx_start` returns 0 after one cycle; `tx_done` ->WAIT_A. Operand registers keep their values until overwritten.
- `rx_done` in COMPUTE or WAIT_TX: byte discarded, `overrun`<=1; cleared only by reset.
- `tx_done` outside WAIT_TX: ignored. No undefined state: unused encodings ->WAIT_A.
- Reset values: `dato_a`,`dato_b`,`opcode`,`tx_data` = 0; `tx_start`,`busy`,`overrun`,`timeout` = 0.
- Reset asserted mid-sequence: immediate return to WAIT_A, all outputs to reset values, partial bytes lost.

## Timing
- `rx_done` sampled at edge N -> captured register valid after edge N.
- Opcode captured at edge K; `tx_data` valid and `tx_start`=1 after edge K+1; `tx_start`=0 after edge K+2.
- `busy` asserted from edge K through the edge that samples `tx_done`.
- `tx_done` at edge M -> in WAIT_A after M; `rx_done` at M+1 is accepted as the next A.
- Back-to-back `rx_done` on consecutive cycles accepted (one byte per cycle).

## Configuration
- `ALU_IF_TIMEOUT_EN` defined: counter runs in WAIT_B and WAIT_OP, cleared on every accepted byte and on entry to WAIT_A; on reaching `TIMEOUT_CYCLES-1` without `rx_done`, FSM ->WAIT_A and `timeout` pulses one cycle. `rx_done` on the same cycle as expiry wins (byte accepted, no timeout).
- Not defined: no counter logic; `timeout` tied 0; FSM waits indefinitely; `TIMEOUT_CYCLES` unused.

## Structure
- Package `alu_pkg`: FSM state encoding and ALU opcode constants (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111), shared with ALU and benches.
- Sub-module `byte_timeout`: counter, clear/enable inputs, `expired` pulse; instantiated only under `ALU_IF_TIMEOUT_EN`.

## Test plan
- Reset, then bytes 0x05, 0x03, 0x20 with ALU model -> `dato_a`=0x05, `dato_b`=0x03, `opcode`=0x20, `tx_data`=0x08, `tx_start` one cycle, 2 edges after opcode byte.
- Opcode byte 0xE2 after 0x03, 0x05 -> `opcode`=0x22, `tx_data`=0xFE (SUB wrap).
- Byte 0x11 during WAIT_TX -> dropped, `overrun`=1, state unchanged; after `tx_done` next byte loads `dato_a`.
- Reset pulse after A=0xAA received -> WAIT_A, all outputs 0; next byte loads `dato_a`.
- With macro, `TIMEOUT_CYCLES`=16: send A only, wait 16 cycles -> `timeout` pulse, next byte 0x07 loads `dato_a`, not `dato_b`.
- Without macro: 1000 idle cycles in WAIT_B -> no abort, `timeout`=0, following byte loads `dato_b`.
